// File: rtl/local_time_adj.sv
// Local time counter with fractional rate trim, offset correction and period pulse.
// Define LOCAL_TIME_SLEW_EN to slew offsets in SLEW_NS chunks; otherwise offsets are stepped in one cycle.
module local_time_adj #(
  parameter int CNT_WIDTH   = 64,
  parameter int NS_PER_CLK  = 8,
  parameter int FRAC_WIDTH  = 16,
  parameter int SLEW_NS     = 1,
  parameter int PERIOD_LOG2 = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [FRAC_WIDTH-1:0] iv_rate_adj,
  input  logic                  i_rate_wr,
  input  logic [31:0]           iv_offset,
  input  logic                  i_offset_wr,
  input  logic [CNT_WIDTH-1:0]  iv_set_value,
  input  logic                  i_set_time,
  output logic [CNT_WIDTH-1:0]  ov_local_cnt,
  output logic                  o_adj_busy,
  output logic                  o_period_pulse
);

  localparam int ACC_W = CNT_WIDTH + FRAC_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SLEW = 2'd2
  } state_t;

  state_t                        state;
  logic [FRAC_WIDTH-1:0]         frac;
  logic signed [FRAC_WIDTH-1:0]  rate_reg;
  logic signed [31:0]            rem;

  logic signed [31:0]            corr;
  logic [ACC_W-1:0]              rate_ext;
  logic [CNT_WIDTH-1:0]          corr_ext;
  logic [ACC_W-1:0]              acc_next;
  logic                          pulse_next;
`ifdef LOCAL_TIME_SLEW_EN
  localparam logic signed [31:0] SLEW_MAX = 32'(SLEW_NS);
  logic signed [31:0]            rem_after;
`endif

  // Correction chunk for this cycle; a fresh offset write takes effect from the next edge.
  always_comb begin
    corr = 32'sd0;
`ifdef LOCAL_TIME_SLEW_EN
    rem_after = rem;
`endif
    if ((state != IDLE) && !i_offset_wr) begin
`ifdef LOCAL_TIME_SLEW_EN
      if (rem > SLEW_MAX) begin
        corr = SLEW_MAX;
      end else if (rem < -SLEW_MAX) begin
        corr = -SLEW_MAX;
      end else begin
        corr = rem;
      end
      rem_after = rem - corr;
`else
      corr = rem;
`endif
    end else begin
      corr = 32'sd0;
    end
  end

  // Next accumulator value and period-index change detection.
  always_comb begin
    rate_ext   = ACC_W'(rate_reg);
    corr_ext   = CNT_WIDTH'(corr);
    acc_next   = {ov_local_cnt, frac}
               + {CNT_WIDTH'(NS_PER_CLK), {FRAC_WIDTH{1'b0}}}
               + rate_ext
               + {corr_ext, {FRAC_WIDTH{1'b0}}};
    pulse_next = (acc_next[ACC_W-1:FRAC_WIDTH+PERIOD_LOG2] != ov_local_cnt[CNT_WIDTH-1:PERIOD_LOG2]);
  end

  // Counter, rate register and offset state machine.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_local_cnt   <= {CNT_WIDTH{1'b0}};
      frac           <= {FRAC_WIDTH{1'b0}};
      rate_reg       <= {FRAC_WIDTH{1'b0}};
      rem            <= 32'sd0;
      state          <= IDLE;
      o_adj_busy     <= 1'b0;
      o_period_pulse <= 1'b0;
    end else begin
      if (i_rate_wr) begin
        rate_reg <= iv_rate_adj;
      end
      if (i_set_time) begin
        ov_local_cnt   <= iv_set_value;
        frac           <= {FRAC_WIDTH{1'b0}};
        rem            <= 32'sd0;
        state          <= IDLE;
        o_adj_busy     <= 1'b0;
        o_period_pulse <= 1'b0;
      end else begin
        {ov_local_cnt, frac} <= acc_next;
        o_period_pulse       <= pulse_next;
        if (i_offset_wr) begin
          // A new write replaces whatever remains; zero cancels.
          rem <= iv_offset;
          if (iv_offset != 32'd0) begin
            state      <= PEND;
            o_adj_busy <= 1'b1;
          end else begin
            state      <= IDLE;
            o_adj_busy <= 1'b0;
          end
        end else begin
          case (state)
            IDLE: begin
              o_adj_busy <= 1'b0;
            end
`ifdef LOCAL_TIME_SLEW_EN
            PEND, SLEW: begin
              rem <= rem_after;
              if (rem_after == 32'sd0) begin
                state      <= IDLE;
                o_adj_busy <= 1'b0;
              end else begin
                state      <= SLEW;
                o_adj_busy <= 1'b1;
              end
            end
`else
            PEND: begin
              rem        <= 32'sd0;
              state      <= IDLE;
              o_adj_busy <= 1'b0;
            end
`endif
            default: begin
              rem        <= 32'sd0;
              state      <= IDLE;
              o_adj_busy <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_local_time_adj.sv
// Directed bench for local_time_adj (default parameters); slew checks build when LOCAL_TIME_SLEW_EN is defined.
module tb_local_time_adj;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rate_adj;
  logic        rate_wr;
  logic [31:0] offset;
  logic        offset_wr;
  logic [63:0] set_value;
  logic        set_time;
  logic [63:0] local_cnt;
  logic        adj_busy;
  logic        period_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  local_time_adj dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .iv_rate_adj    (rate_adj),
    .i_rate_wr      (rate_wr),
    .iv_offset      (offset),
    .i_offset_wr    (offset_wr),
    .iv_set_value   (set_value),
    .i_set_time     (set_time),
    .ov_local_cnt   (local_cnt),
    .o_adj_busy     (adj_busy),
    .o_period_pulse (period_pulse)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge with strobes asserted as currently staged, then strobes dropped.
  task automatic tick_clear();
    tick();
    rate_wr   = 1'b0;
    offset_wr = 1'b0;
    set_time  = 1'b0;
  endtask

  task automatic do_set(input logic [63:0] v);
    set_value = v;
    set_time  = 1'b1;
    tick_clear();
  endtask

  task automatic do_offset(input logic [31:0] v);
    offset    = v;
    offset_wr = 1'b1;
    tick_clear();
  endtask

  initial begin
    rst_n     = 1'b0;
    rate_adj  = 16'd0;
    rate_wr   = 1'b0;
    offset    = 32'd0;
    offset_wr = 1'b0;
    set_value = 64'd0;
    set_time  = 1'b0;
    #12;
    check_val("rst_cnt", local_cnt, 64'd0);
    check_val("rst_busy", {63'd0, adj_busy}, 64'd0);
    check_val("rst_pulse", {63'd0, period_pulse}, 64'd0);
    rst_n = 1'b1;

    repeat (9) tick();
    check_val("run9_cnt", local_cnt, 64'd72);
    // Rate written on the edge that yields 80.
    rate_adj = 16'd16384;
    rate_wr  = 1'b1;
    tick_clear();
    check_val("run10_cnt", local_cnt, 64'd80);
    check_val("run10_busy", {63'd0, adj_busy}, 64'd0);
    check_val("run10_pulse", {63'd0, period_pulse}, 64'd0);
    repeat (4) tick();
    check_val("rate_4cyc", local_cnt, 64'd113);
    repeat (4) tick();
    check_val("rate_8cyc", local_cnt, 64'd146);

    // Rate back to 0 in the same cycle as a set.
    rate_adj = 16'd0;
    rate_wr  = 1'b1;
    do_set(64'd992);
    check_val("set_992", local_cnt, 64'd992);
    tick();
    check_val("set_rate0", local_cnt, 64'd1000);
    do_set(64'd992);

`ifdef LOCAL_TIME_SLEW_EN
    do_offset(32'd5);
    check_val("slew_wr_cnt", local_cnt, 64'd1000);
    check_val("slew_wr_busy", {63'd0, adj_busy}, 64'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_val("slew_cnt", local_cnt, 64'(1000 + 9 * i));
      check_val("slew_busy", {63'd0, adj_busy}, (i < 5) ? 64'd1 : 64'd0);
    end
    tick();
    check_val("slew_after", local_cnt, 64'd1053);

    do_set(64'd992);
    do_offset(32'd5);
    tick();
    tick();
    check_val("slew2_pre", local_cnt, 64'd1018);
    do_offset(32'd3);
    check_val("slew2_wr", local_cnt, 64'd1026);
    check_val("slew2_wr_busy", {63'd0, adj_busy}, 64'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_val("slew2_cnt", local_cnt, 64'(1026 + 9 * i));
    end
    check_val("slew2_busy", {63'd0, adj_busy}, 64'd0);
    tick();
    check_val("slew2_after", local_cnt, 64'd1061);
`else
    do_offset(-32'sd100);
    check_val("step_wr_cnt", local_cnt, 64'd1000);
    check_val("step_wr_busy", {63'd0, adj_busy}, 64'd1);
    tick();
    check_val("step_cnt", local_cnt, 64'd908);
    check_val("step_busy", {63'd0, adj_busy}, 64'd0);
    tick();
    check_val("step_after", local_cnt, 64'd916);
`endif

    // Period boundary from a normal increment.
    do_set(64'd1048560);
    check_val("per_set_pulse", {63'd0, period_pulse}, 64'd0);
    tick();
    check_val("per_pre_cnt", local_cnt, 64'd1048568);
    check_val("per_pre_pulse", {63'd0, period_pulse}, 64'd0);
    tick();
    check_val("per_cnt", local_cnt, 64'd1048576);
    check_val("per_pulse", {63'd0, period_pulse}, 64'd1);
    tick();
    check_val("per_post_pulse", {63'd0, period_pulse}, 64'd0);

    // Wrap-around; the set itself changes period index but must not pulse.
    do_set(64'hFFFF_FFFF_FFFF_FFF8);
    check_val("wrap_set_pulse", {63'd0, period_pulse}, 64'd0);
    tick();
    check_val("wrap_cnt", local_cnt, 64'd0);
    check_val("wrap_pulse", {63'd0, period_pulse}, 64'd1);
    tick();
    check_val("wrap_next", local_cnt, 64'd8);
    check_val("wrap_post_pulse", {63'd0, period_pulse}, 64'd0);

    // Set and offset write in the same cycle: offset dropped.
    offset    = 32'd50;
    offset_wr = 1'b1;
    do_set(64'd5000);
    check_val("setoff_cnt", local_cnt, 64'd5000);
    check_val("setoff_busy", {63'd0, adj_busy}, 64'd0);
    tick();
    tick();
    check_val("setoff_after", local_cnt, 64'd5016);

    // Set while a correction is pending.
    do_offset(32'd50);
    check_val("pend_busy", {63'd0, adj_busy}, 64'd1);
`ifdef LOCAL_TIME_SLEW_EN
    tick();
    check_val("midslew_cnt", local_cnt, 64'd5033);
`endif
    do_set(64'd7000);
    check_val("setpend_cnt", local_cnt, 64'd7000);
    check_val("setpend_busy", {63'd0, adj_busy}, 64'd0);
    tick();
    tick();
    check_val("setpend_after", local_cnt, 64'd7016);

    // Asynchronous reset with a correction pending.
    do_offset(32'd30);
    check_val("rstpend_busy", {63'd0, adj_busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_cnt", local_cnt, 64'd0);
    check_val("arst_busy", {63'd0, adj_busy}, 64'd0);
    check_val("arst_pulse", {63'd0, period_pulse}, 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check_val("arst_first", local_cnt, 64'd8);
    tick();
    check_val("arst_second", local_cnt, 64'd16);
    check_val("arst_busy2", {63'd0, adj_busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/local_time_adj.md
# local_time_adj

Parametrised local time counter that generalises the fixed 8 ns/cycle free-running counter. It adds fractional rate correction, signed offset correction (step or slew), absolute time load, and a periodic pulse aligned to the local time. It sits in the time-synchronisation path, between the sync-algorithm register interface (rate, offset and set writes) and all consumers of local time (timestamping, gate-control scheduling, report pulses).

## Interface
Parameters:
- CNT_WIDTH, 64: local time width in ns.
- NS_PER_CLK, 8: nominal integer ns added per i_clk cycle.
- FRAC_WIDTH, 16: fractional-ns bits in the accumulator and in the rate word.
- SLEW_NS, 1: maximum extra ns applied per cycle while slewing (used only with SLEW_EN).
- PERIOD_LOG2, 20: pulse period is 2^PERIOD_LOG2 ns.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- iv_rate_adj  in  FRAC_WIDTH  signed rate correction, units of 2^-FRAC_WIDTH ns per cycle.
- i_rate_wr  in  1  one-cycle strobe; latches iv_rate_adj.
- iv_offset  in  32  signed offset correction in ns.
- i_offset_wr  in  1  one-cycle strobe; latches iv_offset.
- iv_set_value  in  CNT_WIDTH  absolute time to load.
- i_set_time  in  1  one-cycle strobe; loads iv_set_value.
- ov_local_cnt  out  CNT_WIDTH  local time in ns (registered).
- o_adj_busy  out  1  high while an offset correction is pending or in progress.
- o_period_pulse  out  1  one-cycle pulse on each period boundary crossing.

## Operation
- Internal accumulator is {ov_local_cnt, frac[FRAC_WIDTH-1:0]}. Each cycle it adds {NS_PER_CLK, 0} + sign_extend(rate_reg) + correction, where correction is an integer ns value shifted into the ns field.
- All arithmetic is modulo 2^(CNT_WIDTH+FRAC_WIDTH). Wrap-around past all-ones is silent and continues from 0.
- rate_reg holds its value until the next i_rate_wr. Reset value 0 gives exactly NS_PER_CLK ns per cycle.
- Offset state machine has three states:
  - IDLE to PEND on i_offset_wr with a nonzero value. An offset of 0 is ignored.
  - PEND applies the correction (step or slew; see Configuration).
  - SLEW (SLEW_EN only) continues until the remaining offset reaches 0, then returns to IDLE.
  - o_adj_busy = (state != IDLE).
- i_offset_wr while in PEND or SLEW replaces the remaining offset with the new value. It does not accumulate.
- i_set_time has highest priority:
  - ov_local_cnt <= iv_set_value and frac <= 0.
  - Any pending or ongoing offset is discarded and the state goes to IDLE.
  - An i_offset_wr in the same cycle is dropped.
  - i_rate_wr in the same cycle is still honoured.
- o_period_pulse is registered. It is high for exactly one cycle when ov_local_cnt[CNT_WIDTH-1:PERIOD_LOG2] changes between consecutive values:
  - The pulse covers normal increments, step corrections, slew corrections and wrap-around.
  - The pulse is suppressed on the cycle of a set-time load.
- Reset values: ov_local_cnt = 0, frac = 0, rate_reg = 0, remaining offset = 0, state = IDLE, o_adj_busy = 0, o_period_pulse = 0.

## Timing
- ov_local_cnt changes on every rising i_clk after reset release. The first value after release is NS_PER_CLK.
- A rate written at edge N first affects the increment at edge N+1.
- An offset written at edge N: o_adj_busy is high after edge N, and the first correction is applied at edge N+1.
- A set sampled at edge N: ov_local_cnt equals iv_set_value immediately after edge N, and normal increments resume at edge N+1.
- o_period_pulse is high in the same cycle that ov_local_cnt first shows the new period index, with zero extra latency relative to the counter.
- Asynchronous reset mid-slew or mid-pend forces all outputs to their reset values immediately. No correction survives reset.

## Configuration
- Macro LOCAL_TIME_SLEW_EN.
- Defined (slew mode):
  - PEND goes to SLEW.
  - Each cycle adds sign(rem)·min(|rem|, SLEW_NS) ns and decrements |rem| by the same amount.
  - The state returns to IDLE on the cycle the final chunk is applied. o_adj_busy falls on that edge.
  - Time never steps by more than NS_PER_CLK + SLEW_NS per cycle, and never goes backwards while SLEW_NS < NS_PER_CLK.
- Undefined (step mode):
  - The SLEW state and the SLEW_NS logic are absent.
  - At edge N+1 the full offset is added in one cycle (ov_local_cnt += NS_PER_CLK + offset) and the state returns to IDLE.
  - o_adj_busy is high for exactly one cycle.

## Test plan
- Reset, release, run 10 cycles (defaults, rate 0) -> ov_local_cnt = 80, o_adj_busy = 0, no pulse.
- Write rate +16384 (0.25 ns/cycle) at cnt = 80, run 4 cycles -> cnt = 80 + 33 = 113, frac = 0.
- Step mode, offset -100 at cnt = 1000 -> next value 908, then 916; o_adj_busy high for 1 cycle.
- Slew mode with SLEW_NS = 1, offset +5 at cnt = 1000 -> five increments of 9 (1009 … 1045), then increments of 8; o_adj_busy low after the fifth. Write a second offset of +3 after the second increment -> exactly three more increments of 9.
- Set 2^20 - 16 -> two edges later cnt = 2^20 with o_period_pulse high for one cycle. Set all-ones - 7 -> next cnt = 0 with a pulse (wrap).
- Set time in the same cycle as offset_wr and during an active slew -> cnt = set value, o_adj_busy = 0, no correction applied afterwards.
